cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Collects completion results from the execution units and broadcasts at most one per cycle on the common data bus (CDB). The CDB is the wakeup source for every reservation station and the completion source for the ROB and physical register file. Each source gets a 2-entry buffer, so a unit can complete while the bus is busy. A round-robin arbiter selects among buffered results, and the selected result is registered onto the bus.

## Interface
- `N_SRC`, default 3: number of execution-unit sources (0 = ALU, 1 = branch, 2 = LSU).
- `FIFO_DEPTH`, default 2: entries per source buffer. Fixed at 2; other values are unsupported.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `flush_i`  in  1  pipeline flush; discards all buffered and in-flight results.
- `src_valid_i`  in  `N_SRC`  per-source completion valid.
- `src_ready_o`  out  `N_SRC`  per-source buffer not full.
- `src_pkt_i`  in  `N_SRC` x `cdb_pkt_t`  per-source result, with fields:
  - `rob_tag` (`ROB_TAG_W`)
  - `rd_used` (1)
  - `rd_tag` (`PREG_W`)
  - `data` (`XLEN`)
- `cdb_valid_o`  out  1  broadcast valid.
- `cdb_pkt_o`  out  `cdb_pkt_t`  broadcast payload.
- `wakeup_valid_o`  out  1  equals `cdb_valid_o && cdb_pkt_o.rd_used`; feeds the reservation-station wakeup input.
- `wakeup_tag_o`  out  `PREG_W`  equals `cdb_pkt_o.rd_tag`.

## Operation
- **Acceptance.** Source i is accepted when `src_valid_i[i] && src_ready_o[i]`. The packet is written at the tail of buffer i.
- **Ready.** `src_ready_o[i] = (count_i < 2)`. This is derived from registered count only. Ready is 0 while full, even in a cycle where that buffer is popped; there is no pop-then-push forwarding.
- **Requests.** `req[i] = (count_i != 0)`.
- **Grant.** The grant is the first requesting index found scanning cyclically from `rr_q` (`rr_q`, `rr_q+1`, …, wrapping modulo `N_SRC`).
- **Grant effects.** When any request is granted:
  - the head of the granted buffer pops;
  - the output register loads the head packet with valid=1;
  - `rr_q <= (grant == N_SRC-1) ? 0 : grant+1`.
- **No request.** If there is no request, output valid loads 0 and `rr_q` holds.
- **Bus consumers.** CDB consumers cannot stall the bus. The broadcast lasts exactly one cycle per result.
- **Buffers.** Each buffer is FIFO-ordered, with 1-bit head/tail pointers that wrap 1→0. Count is 2 bits, range 0..2. A simultaneous push and pop keeps count unchanged.
- **Flush.** When `flush_i`=1 at an edge:
  - all counts and pointers go to 0;
  - output valid goes to 0;
  - `rr_q` goes to 0;
  - pushes and the grant in that cycle are discarded.
  
  Flush has priority over every other update. `src_ready_o` reads 1 in the cycle after the flush.
- **Reset.** Reset gives the same state as flush. `cdb_pkt_o` payload registers reset to `'0`. All outputs read 0 after reset except `src_ready_o`, which reads all-ones.
- **Reset mid-operation.** All buffered results are lost; there is no partial broadcast.

## Timing
- **Minimum latency.** Handshake accepted in cycle t, buffer empty, and source wins arbitration in t+1: `cdb_valid_o` is high in cycle t+2.
- **Throughput.** One broadcast per cycle sustained while any buffer is non-empty.
- **Fairness.** A continuously requesting source waits at most `N_SRC-1` grants.
- **Backpressure.** A source that keeps valid high with ready low must hold its packet stable; this is the source's responsibility. The arbiter samples the packet only when ready=1.
- **Reservation-station wakeup.** `wakeup_valid_o`/`wakeup_tag_o` are registered outputs. A reservation station sees the wakeup in the same cycle as `cdb_valid_o` and marks its operand ready at the following edge.

## Structure
- `cdb_pkt_t` goes in `ooop_types.sv`. `N_CDB_SRC` = 3 goes in `ooop_defs.vh`.
- One sub-module, `cdb_src_fifo`: a 2-entry synchronous FIFO with `push`, `pop`, `flush`, `count` and `head` ports. It is instantiated `N_SRC` times in a generate loop.
- Arbiter selection and the output register are in the top module.

## Test plan
- **Reset.** Hold rst_n=0 for 2 cycles, then release → `cdb_valid_o`=0, `wakeup_valid_o`=0, `src_ready_o`=3'b111, `cdb_pkt_o`=0.
- **Single result.** Push one packet on src1 in cycle 5 (rob_tag=4, rd_used=1, rd_tag=17, data=0xDEADBEEF) → in cycle 7 `cdb_valid_o`=1, `wakeup_tag_o`=17, data=0xDEADBEEF; cycle 8 valid=0.
- **Round-robin.** All three sources push in the same cycle with rob_tags 10/11/12, starting from `rr_q`=0 → broadcasts in order 10, 11, 12 on consecutive cycles. Then refill only src0 and src2 → src0 then src2.
- **Full buffer.** Push 3 back-to-back packets on src2 while src0 is continuously busy → `src_ready_o[2]` goes 0 after 2 accepted packets. The third packet is accepted only after a src2 pop. All three broadcast in FIFO order with no loss or duplication.
- **No rd.** Push with rd_used=0, rd_tag=9 → `cdb_valid_o`=1 but `wakeup_valid_o`=0.
- **Flush.** With 2 packets buffered in each source, assert `flush_i` for one cycle coincident with a new push → no further `cdb_valid_o`. The next cycle `src_ready_o`=3'b111, and a subsequent push on src0 broadcasts normally with `rr_q` restarted at 0.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
//   Shared types and constants for the common data bus (CDB) arbiter.
//   - cdb_pkt_t   : one completion result as carried on the CDB
//   - N_CDB_SRC   : number of execution-unit sources (ALU, branch, LSU)
//   - rr_advance  : round-robin pointer step, wrapping to 0 after last source
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

  localparam int N_CDB_SRC = 3;
  localparam int ROB_TAG_W = 6;
  localparam int PREG_W    = 7;
  localparam int XLEN      = 32;

  // Source numbering on the arbiter inputs.
  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_BR  = 2'd1,
    SRC_LSU = 2'd2
  } cdb_src_e;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob_tag;
    logic                 rd_used;
    logic [PREG_W-1:0]    rd_tag;
    logic [XLEN-1:0]      data;
  } cdb_pkt_t;

  // Next round-robin start position after 'grant' won: the source just
  // served drops to lowest priority.
  function automatic int rr_advance(input int grant, input int n_src);
    return (grant == n_src - 1) ? 0 : grant + 1;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// -----------------------------------------------------------------------------
// cdb_src_fifo
//   Two-entry synchronous FIFO buffering completions from one execution unit.
//   The head entry is read combinationally so the arbiter can pop it and load
//   it into the bus register on the same edge.
//
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     flush        discard all entries (priority over push/pop)
//     push         write push_pkt at the tail (caller guarantees count < 2)
//     push_pkt     packet to write
//     pop          drop the head entry (caller guarantees count != 0)
//     count        number of valid entries, 0..2
//     head         oldest entry (undefined content when count == 0)
// -----------------------------------------------------------------------------
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  cdb_pkt_t   push_pkt,
  input  logic       pop,
  output logic [1:0] count,
  output cdb_pkt_t   head
);

  cdb_pkt_t   mem_reg [2];
  logic       head_ptr_reg;
  logic       tail_ptr_reg;
  logic [1:0] count_reg;
  logic [1:0] count_next;
  logic       clear;

  assign clear = !rst_n || flush;

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (!clear && push) begin
      mem_reg[tail_ptr_reg] <= push_pkt;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;  // idle, or push+pop keeps occupancy
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      head_ptr_reg <= 1'b0;
      tail_ptr_reg <= 1'b0;
      count_reg    <= 2'd0;
    end else begin
      if (push) tail_ptr_reg <= ~tail_ptr_reg;
      if (pop)  head_ptr_reg <= ~head_ptr_reg;
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
  assign head  = mem_reg[head_ptr_reg];

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Collects completions from N_SRC execution units, buffers each in a 2-entry
//   FIFO and broadcasts at most one per cycle on the common data bus. A
//   round-robin arbiter picks among non-empty buffers; the winner's head is
//   registered onto the bus, so every output comes straight from a flop.
//
//   Ports:
//     clk, rst_n      clock, synchronous active-low reset
//     flush_i         drop all buffered and in-flight results
//     src_valid_i     per-source completion valid
//     src_ready_o     per-source buffer not full (from registered count only)
//     src_pkt_i       per-source completion packet
//     cdb_valid_o     bus broadcast valid (one cycle per result)
//     cdb_pkt_o       bus broadcast payload
//     wakeup_valid_o  broadcast carries a destination register
//     wakeup_tag_o    destination physical register tag
// -----------------------------------------------------------------------------
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC      = N_CDB_SRC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic [N_SRC-1:0]        src_valid_i,
  output logic [N_SRC-1:0]        src_ready_o,
  input  cdb_pkt_t [N_SRC-1:0]    src_pkt_i,
  output logic                    cdb_valid_o,
  output cdb_pkt_t                cdb_pkt_o,
  output logic                    wakeup_valid_o,
  output logic [PREG_W-1:0]       wakeup_tag_o
);

  localparam int         RR_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

  // Per-source buffer state.
  logic [1:0]       count [N_SRC];
  cdb_pkt_t         head  [N_SRC];
  logic [N_SRC-1:0] push;
  logic [N_SRC-1:0] pop;
  logic [N_SRC-1:0] req;

  // Arbitration.
  logic [RR_W-1:0]  rr_reg;
  logic [RR_W-1:0]  rr_next;
  logic             grant_valid;
  logic [RR_W-1:0]  grant_idx;
  cdb_pkt_t         grant_pkt;
  int               scan_idx;

  // Bus output register.
  logic             cdb_valid_reg;
  cdb_pkt_t         cdb_pkt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      // Ready ignores a same-cycle pop: a full buffer never accepts, even
      // while it is being drained, which keeps ready a pure flop output.
      assign src_ready_o[gi] = (count[gi] < FULL_COUNT);
      assign req[gi]         = (count[gi] != 2'd0);
      assign push[gi]        = src_valid_i[gi] && src_ready_o[gi];
      assign pop[gi]         = grant_valid && (grant_idx == RR_W'(gi));

      cdb_src_fifo u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush_i),
        .push     (push[gi]),
        .push_pkt (src_pkt_i[gi]),
        .pop      (pop[gi]),
        .count    (count[gi]),
        .head     (head[gi])
      );
    end
  endgenerate

  // Scan cyclically starting at rr_reg; the first requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_pkt   = '0;
    scan_idx    = 0;
    for (int k = 0; k < N_SRC; k++) begin
      scan_idx = int'(rr_reg) + k;
      if (scan_idx >= N_SRC) scan_idx = scan_idx - N_SRC;
      if (!grant_valid && req[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = RR_W'(scan_idx);
        grant_pkt   = head[scan_idx];
      end
    end
  end

  assign rr_next = RR_W'(rr_advance(int'(grant_idx), N_SRC));

  // Flush shares the reset path: a grant made on the flush edge is dropped,
  // and the matching FIFO pop is suppressed by the FIFO's own flush.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      cdb_valid_reg <= 1'b0;
      cdb_pkt_reg   <= '0;
      rr_reg        <= '0;
    end else begin
      cdb_valid_reg <= grant_valid;
      if (grant_valid) begin
        cdb_pkt_reg <= grant_pkt;
        rr_reg      <= rr_next;
      end
    end
  end

  assign cdb_valid_o    = cdb_valid_reg;
  assign cdb_pkt_o      = cdb_pkt_reg;
  assign wakeup_valid_o = cdb_valid_reg && cdb_pkt_reg.rd_used;
  assign wakeup_tag_o   = cdb_pkt_reg.rd_tag;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//   Scoreboard bench for cdb_arbiter. The stimulus process keeps a reference
//   model (one packet queue per source plus a round-robin start index) and
//   pushes each expected broadcast, tagged with the clock edge after which it
//   must appear, into a scoreboard queue. A separate monitor pops and compares
//   whenever the bus shows valid, and flags expected results that never came.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                flush_i = 1'b0;
  logic [N-1:0]        src_valid_i = '0;
  logic [N-1:0]        src_ready_o;
  cdb_pkt_t [N-1:0]    src_pkt_i = '0;
  logic                cdb_valid_o;
  cdb_pkt_t            cdb_pkt_o;
  logic                wakeup_valid_o;
  logic [PREG_W-1:0]   wakeup_tag_o;

  cdb_arbiter #(.N_SRC(N), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .src_valid_i    (src_valid_i),
    .src_ready_o    (src_ready_o),
    .src_pkt_i      (src_pkt_i),
    .cdb_valid_o    (cdb_valid_o),
    .cdb_pkt_o      (cdb_pkt_o),
    .wakeup_valid_o (wakeup_valid_o),
    .wakeup_tag_o   (wakeup_tag_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       edge_no;
    cdb_pkt_t pkt;
  } sb_t;

  int       vectors = 0;
  int       miscompares = 0;
  int       edge_cnt = 0;
  sb_t      sb_q [$];
  cdb_pkt_t mq [N][$];   // model: packets held per source, oldest first
  int       rr_m = 0;    // model: where the next round-robin scan starts

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, got, want, edge_cnt);
    end
  endtask

  function automatic cdb_pkt_t mk(input int rob, input bit used, input int tag, input logic [31:0] d);
    cdb_pkt_t p;
    p.rob_tag = ROB_TAG_W'(rob);
    p.rd_used = used;
    p.rd_tag  = PREG_W'(tag);
    p.data    = d;
    return p;
  endfunction

  function automatic cdb_pkt_t rnd_pkt();
    return mk(int'($urandom_range(63)), 1'($urandom_range(1)), int'($urandom_range(127)), $urandom);
  endfunction

  // One clock of stimulus: check ready against the model, drive inputs,
  // then advance the model to the state after the coming edge.
  task automatic step(input logic [N-1:0] v, input cdb_pkt_t [N-1:0] p,
                      input logic fl, input logic rs, output logic [N-1:0] acc);
    logic [N-1:0] exp_rdy;
    int idx;
    sb_t e;
    @(negedge clk);
    for (int i = 0; i < N; i++) exp_rdy[i] = (mq[i].size() < 2);
    chk("src_ready", 64'(src_ready_o), 64'(exp_rdy));
    src_valid_i = v;
    src_pkt_i   = p;
    flush_i     = fl;
    rst_n       = !rs;
    acc = '0;
    if (fl || rs) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      rr_m = 0;
    end else begin
      for (int i = 0; i < N; i++) acc[i] = v[i] && exp_rdy[i];
      for (int k = 0; k < N; k++) begin
        idx = (rr_m + k) % N;
        if (mq[idx].size() > 0) begin
          e.edge_no = edge_cnt + 1;
          e.pkt     = mq[idx].pop_front();
          sb_q.push_back(e);
          rr_m = (idx + 1) % N;
          break;
        end
      end
      for (int i = 0; i < N; i++) if (acc[i]) mq[i].push_back(p[i]);
    end
  endtask

  // Monitor: every broadcast must match the oldest expected result and land
  // on the expected edge; an expected result that is overdue is a miss.
  always @(posedge clk) begin
    sb_t e;
    edge_cnt <= edge_cnt + 1;
    #1;
    if (cdb_valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_bcast", 64'(cdb_pkt_o), 64'(0));
      end else begin
        e = sb_q.pop_front();
        chk("bcast_edge", 64'(edge_cnt), 64'(e.edge_no));
        chk("cdb_pkt", 64'(cdb_pkt_o), 64'(e.pkt));
        chk("wakeup_valid", 64'(wakeup_valid_o), 64'(e.pkt.rd_used));
        chk("wakeup_tag", 64'(wakeup_tag_o), 64'(e.pkt.rd_tag));
      end
    end else if (rst_n === 1'b1) begin
      chk("wakeup_idle", 64'(wakeup_valid_o), 64'(0));
      if (sb_q.size() > 0 && sb_q[0].edge_no <= edge_cnt) begin
        e = sb_q.pop_front();
        chk("missing_bcast", 64'(cdb_valid_o), 64'(1));
      end
    end
  end

  initial begin
    logic [N-1:0]     v;
    logic [N-1:0]     acc;
    logic [N-1:0]     hold;
    cdb_pkt_t [N-1:0] p;
    int               sent;

    v = '0; p = '0; hold = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cdb_valid", 64'(cdb_valid_o), 64'(0));
    chk("rst_wakeup_valid", 64'(wakeup_valid_o), 64'(0));
    chk("rst_ready", 64'(src_ready_o), 64'(3'b111));
    chk("rst_cdb_pkt", 64'(cdb_pkt_o), 64'(0));
    chk("rst_wakeup_tag", 64'(wakeup_tag_o), 64'(0));

    // Single result on src1.
    repeat (2) step('0, p, 1'b0, 1'b0, acc);
    p[1] = mk(4, 1'b1, 17, 32'hDEADBEEF);
    step(3'b010, p, 1'b0, 1'b0, acc);
    repeat (3) step('0, p, 1'b0, 1'b0, acc);

    // Round-robin from a freshly restarted pointer.
    step('0, p, 1'b1, 1'b0, acc);
    p[0] = mk(10, 1'b1, 1, 32'h10); p[1] = mk(11, 1'b1, 2, 32'h11); p[2] = mk(12, 1'b1, 3, 32'h12);
    step(3'b111, p, 1'b0, 1'b0, acc);
    repeat (4) step('0, p, 1'b0, 1'b0, acc);
    p[0] = mk(13, 1'b1, 4, 32'h13); p[2] = mk(14, 1'b0, 5, 32'h14);
    step(3'b101, p, 1'b0, 1'b0, acc);
    repeat (3) step('0, p, 1'b0, 1'b0, acc);

    // Full buffer on src2 while src0 keeps requesting.
    sent = 0;
    p[0] = rnd_pkt(); p[2] = mk(20, 1'b1, 20, 32'h20);
    for (int c = 0; c < 16 && sent < 3; c++) begin
      v = 3'b101;
      if (sent >= 3) v[2] = 1'b0;
      step(v, p, 1'b0, 1'b0, acc);
      if (acc[0]) p[0] = rnd_pkt();
      if (acc[2]) begin
        sent++;
        p[2] = mk(20 + sent, 1'b1, 20 + sent, 32'h20 + 32'(sent));
      end
    end
    chk("src2_all_sent", 64'(sent), 64'(3));
    repeat (6) step('0, p, 1'b0, 1'b0, acc);

    // Result without a destination register.
    p[0] = mk(30, 1'b0, 9, 32'h30);
    step(3'b001, p, 1'b0, 1'b0, acc);
    repeat (3) step('0, p, 1'b0, 1'b0, acc);

    // Fill all buffers, flush alongside a push, then restart.
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < N; i++) p[i] = rnd_pkt();
      step(3'b111, p, 1'b0, 1'b0, acc);
    end
    step(3'b111, p, 1'b1, 1'b0, acc);
    p[0] = mk(40, 1'b1, 40, 32'h40); p[2] = mk(41, 1'b1, 41, 32'h41);
    step(3'b101, p, 1'b0, 1'b0, acc);
    repeat (4) step('0, p, 1'b0, 1'b0, acc);

    // Random traffic with occasional flush and one reset mid-stream.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          v[i] = ($urandom_range(99) < 55);
          p[i] = rnd_pkt();
        end
      end
      step(v, p, ($urandom_range(59) == 0), (c == 700), acc);
      for (int i = 0; i < N; i++) hold[i] = v[i] && !acc[i] && !flush_i && rst_n;
    end

    hold = '0;
    repeat (8) step('0, p, 1'b0, 1'b0, acc);
    chk("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
